// File: rtl/gpu_bg_line_reader_pkg.sv
// ============================================================================
// Module : gpu_bg_line_reader_pkg
// Brief  : Shared state encodings and default sizes for the BG line reader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gpu_bg_line_reader_pkg;

    localparam int c_LINE_PIXELS_DEFAULT = 160;
    localparam int c_SEL_W_DEFAULT       = 5;

    localparam logic [1:0] GBR_IDLE  = 2'd0;
    localparam logic [1:0] GBR_FETCH = 2'd1;
    localparam logic [1:0] GBR_RUN   = 2'd2;
    localparam logic [1:0] GBR_DONE  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/gpu_bg_line_reader_plane_shifter.sv
// ============================================================================
// Module : gpu_bg_line_reader_plane_shifter
// Brief  : bh/bl plane shift pair with pixel count and one-block prefetch hold.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gpu_bg_line_reader_plane_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] fine,
    input  logic       shift,
    input  logic       fill,
    input  logic [7:0] bh,
    input  logic [7:0] bl,
    output logic [1:0] pix_idx,
    output logic       need_block
);

    logic [7:0] r_bh_sr;
    logic [7:0] r_bl_sr;
    logic [3:0] r_cnt;
    logic [7:0] r_hold_bh;
    logic [7:0] r_hold_bl;
    logic       r_hold_full;
    logic       w_reload;

    assign w_reload   = shift && (r_cnt == 4'd1);
    assign pix_idx    = {r_bl_sr[7], r_bh_sr[7]};
    assign need_block = !r_hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bh_sr     <= 8'd0;
            r_bl_sr     <= 8'd0;
            r_cnt       <= 4'd0;
            r_hold_bh   <= 8'd0;
            r_hold_bl   <= 8'd0;
            r_hold_full <= 1'b0;
        end else begin
            if (load) begin
                r_bh_sr <= bh << fine;
                r_bl_sr <= bl << fine;
                r_cnt   <= 4'd8 - {1'b0, fine};
            end else if (w_reload) begin
                // An empty hold can only coincide with its own fill (fine=7 start),
                // so the incoming block is taken directly in that case.
                r_bh_sr <= r_hold_full ? r_hold_bh : bh;
                r_bl_sr <= r_hold_full ? r_hold_bl : bl;
                r_cnt   <= 4'd8;
            end else if (shift) begin
                r_bh_sr <= {r_bh_sr[6:0], 1'b0};
                r_bl_sr <= {r_bl_sr[6:0], 1'b0};
                r_cnt   <= r_cnt - 4'd1;
            end

            if (fill) begin
                r_hold_bh <= bh;
                r_hold_bl <= bl;
            end

            if (load) begin
                r_hold_full <= 1'b0;
            end else if (w_reload) begin
                r_hold_full <= 1'b0;
            end else if (fill) begin
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpu_bg_line_reader.sv
// ============================================================================
// Module : gpu_bg_line_reader
// Brief  : Streams one scrolled, palette-mapped background line to the LCD.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gpu_bg_line_reader
    import gpu_bg_line_reader_pkg::*;
#(
    parameter int LINE_PIXELS = c_LINE_PIXELS_DEFAULT,
    parameter int SEL_W       = c_SEL_W_DEFAULT
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iLineStart,
    input  logic [7:0]       iScx,
    input  logic [7:0]       iBgp,
    output logic [SEL_W-1:0] oBlockSel,
    input  logic [7:0]       iBlockBh,
    input  logic [7:0]       iBlockBl,
    output logic [1:0]       oPixel,
    output logic             oPixelValid,
    input  logic             iPixelReady,
    output logic [7:0]       oPixelX,
    output logic             oBusy,
    output logic             oLineDone
);

    localparam logic [7:0] c_LAST_X = 8'(LINE_PIXELS - 1);

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic [2:0] r_fine;
    logic [7:0] r_bgp;
    logic       w_start;
    logic       w_xfer;
    logic       w_last;
    logic       w_fill;
    logic       w_need_block;
    logic [1:0] w_idx;

    assign w_start = (r_state == GBR_IDLE) && iLineStart;
    assign w_xfer  = oPixelValid && iPixelReady;
    assign w_last  = w_xfer && (oPixelX == c_LAST_X);
    assign w_fill  = (r_state == GBR_RUN) && w_need_block;

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state <= GBR_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            GBR_IDLE:  if (iLineStart) w_next = GBR_FETCH;
            GBR_FETCH: w_next = GBR_RUN;
            GBR_RUN:   if (w_last) w_next = GBR_DONE;
            GBR_DONE:  w_next = GBR_IDLE;
            default:   w_next = GBR_IDLE;
        endcase
    end

    always_comb begin
        oPixelValid = (r_state == GBR_RUN);
        oBusy       = (r_state != GBR_IDLE);
        oLineDone   = (r_state == GBR_DONE);
        oPixel      = oPixelValid ? r_bgp[{w_idx, 1'b0} +: 2] : 2'd0;
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            r_fine    <= 3'd0;
            r_bgp     <= 8'd0;
            oBlockSel <= '0;
            oPixelX   <= 8'd0;
        end else begin
            if (w_start) begin
                r_fine    <= iScx[2:0];
                r_bgp     <= iBgp;
                oBlockSel <= SEL_W'(iScx[7:3]);
                oPixelX   <= 8'd0;
            end else if ((r_state == GBR_FETCH) || w_fill) begin
                oBlockSel <= oBlockSel + 1'b1;
            end

            if (w_xfer && !w_last) begin
                oPixelX <= oPixelX + 8'd1;
            end
        end
    end

    gpu_bg_line_reader_plane_shifter u_shifter (
        .clk        (iClock),
        .rst_n      (iReset_n),
        .load       (r_state == GBR_FETCH),
        .fine       (r_fine),
        .shift      (w_xfer),
        .fill       (w_fill),
        .bh         (iBlockBh),
        .bl         (iBlockBl),
        .pix_idx    (w_idx),
        .need_block (w_need_block)
    );

endmodule

`default_nettype wire
